alu_op_sequencer: RTL and testbench
===================================

Name: alu_op_sequencer

Overview:
- Command front-end that sits directly upstream of the 8-bit ALU and also consumes its output.
- Buffers incoming operation requests (A, B, Sel) in a small FIFO and drives registered operands into the ALU.
- Waits a fixed settle time, then captures the ALU result and flags into a response register with valid/ready back-pressure.
- Rejects illegal opcodes without issuing them, and keeps a saturating error counter.

Parameters:
FIFO_DEPTH, 4, command FIFO entries; must be a power of 2, ≥2
SETTLE_CYC, 1, cycles the ALU inputs are held before capture; ≥1
CNT_W, 8, width of err_count

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  asynchronous, active-high reset
cmd_valid  in  1  command offered
cmd_ready  out  1  FIFO can accept; equals !fifo_full
cmd_A  in  8  operand A
cmd_B  in  8  operand B
cmd_sel  in  4  ALU opcode; legal range 4'h0..4'hB
alu_A  out  8  registered operand to ALU operand_A
alu_B  out  8  registered operand to ALU operand_B
alu_sel  out  4  registered opcode to ALU Sel
alu_out  in  8  ALU Out
alu_flag  in  4  ALU Flag; [3] underflow/invalid, [2] mul overflow, [1] carry/shift overflow, [0] zero
rsp_valid  out  1  response available
rsp_ready  in  1  consumer accepts response
rsp_data  out  8  captured result
rsp_flag  out  4  captured flags
rsp_illegal  out  1  response is for an illegal opcode
err_count  out  CNT_W  count of erroneous operations; saturating
busy  out  1  state != IDLE or FIFO non-empty

Behaviour:
- Reset (async, rst=1): FIFO empty, FSM=IDLE, settle counter 0. All outputs are 0 except cmd_ready=1: alu_A, alu_B, alu_sel, rsp_*, err_count, busy. A reset mid-operation discards the FIFO contents and any in-flight or pending response.
- FIFO push when cmd_valid && cmd_ready. Push and pop may occur in the same cycle; occupancy is then unchanged. Pointers wrap modulo FIFO_DEPTH. No push when full (cmd_ready=0). No pop when empty.
- FSM states:
  - IDLE: if FIFO non-empty, pop the head entry.
    - Legal sel (≤4'hB): load alu_A/alu_B/alu_sel, load settle counter with SETTLE_CYC, go SETTLE.
    - Illegal sel: alu_* unchanged; set rsp_data=0, rsp_flag=0, rsp_illegal=1, rsp_valid=1; go RESP.
  - SETTLE: decrement the counter each cycle. On the cycle the counter equals 1:
    - capture rsp_data<=alu_out, rsp_flag<=alu_flag, rsp_illegal<=0, rsp_valid<=1;
    - go RESP.
  - RESP: hold rsp_* stable while rsp_valid && !rsp_ready. On rsp_ready: rsp_valid<=0, go IDLE. No pop occurs in RESP.
- alu_A/alu_B/alu_sel hold their last issued values after capture; they are never driven to Z.
- Latency with empty pipe and SETTLE_CYC=1: command accepted at edge 0, popped and issued at edge 1, captured at edge 2. rsp_valid is high after edge 2.
- Throughput: one operation per (2 + SETTLE_CYC) cycles when rsp_ready is held high. The same rule applies with SETTLE_CYC>1.
- err_count: +1 on an illegal opcode response, or on a capture where alu_flag[3:1] != 0. The zero flag alone is not an error. Holds at all-ones (no wrap).
- The FIFO keeps accepting commands while the FSM is stalled in RESP, until full.

Test Plan:
- From reset: push A=0x12, B=0x34, sel=0 → rsp_valid 2 cycles after acceptance; rsp_data=0x46, rsp_flag=0000, err_count=0.
- From reset: push A=0x05, B=0x09, sel=1 → rsp_flag[3]=1, err_count=1, rsp_illegal=0.
- Push sel=4'hE with A=0xFF, B=0xFF → rsp_valid after 1 cycle, rsp_illegal=1, rsp_data=0x00, alu_sel unchanged, err_count=+1.
- Hold rsp_ready=0 and push 5 commands with FIFO_DEPTH=4 → cmd_ready drops after the FIFO fills while the first response is held. Then release rsp_ready → responses emerge in order with values intact.
- Force err_count to all-ones via a CNT_W=2 build and 5 sel=1 underflows → err_count sticks at 2'b11.
- Assert rst while in SETTLE with 3 queued commands → all outputs 0 immediately, cmd_ready=1. After release, no stale response appears.

Source files
------------

// File: rtl/alu_op_sequencer.sv
// Command front-end for the 8-bit ALU. Queues (A, B, Sel) requests, holds the operands
// to the ALU for a settle time, then returns the captured result with valid/ready.
module alu_op_sequencer #(
   parameter int FIFO_DEPTH = 4,
   parameter int SETTLE_CYC = 1,
   parameter int CNT_W      = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [7:0]       cmd_A,
   input  logic [7:0]       cmd_B,
   input  logic [3:0]       cmd_sel,
   output logic [7:0]       alu_A,
   output logic [7:0]       alu_B,
   output logic [3:0]       alu_sel,
   input  logic [7:0]       alu_out,
   input  logic [3:0]       alu_flag,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic [7:0]       rsp_data,
   output logic [3:0]       rsp_flag,
   output logic             rsp_illegal,
   output logic [CNT_W-1:0] err_count,
   output logic             busy
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int SET_W = $clog2(SETTLE_CYC + 1);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETTLE = 2'd1,
      RESP   = 2'd2
   } state_t;

   state_t           state_reg;
   logic [19:0]      mem_reg [FIFO_DEPTH];
   logic [PTR_W-1:0] wr_ptr_reg;
   logic [PTR_W-1:0] rd_ptr_reg;
   logic [PTR_W:0]   count_reg;
   logic [SET_W-1:0] settle_reg;

   logic        push;
   logic        pop;
   logic        fifo_full;
   logic        fifo_empty;
   logic [19:0] head;
   logic        head_legal;
   logic        capture;
   logic        err_inc;

   assign fifo_full  = (count_reg == (PTR_W + 1)'(FIFO_DEPTH));
   assign fifo_empty = (count_reg == '0);
   assign cmd_ready  = !fifo_full;
   assign push       = cmd_valid && !fifo_full;
   assign pop        = (state_reg == IDLE) && !fifo_empty;
   assign head       = mem_reg[rd_ptr_reg];
   assign head_legal = (head[19:16] <= 4'hB);
   assign capture    = (state_reg == SETTLE) && (settle_reg == SET_W'(1));
   assign busy       = (state_reg != IDLE) || !fifo_empty;

   // Zero flag alone is a normal result; only flags [3:1] count as errors.
   assign err_inc = (pop && !head_legal) || (capture && (alu_flag[3:1] != 3'b000));

   // Entry layout: {sel, B, A}. Storage needs no reset; occupancy is tracked by count_reg.
   always_ff @(posedge clk) begin
      if (push) begin
         mem_reg[wr_ptr_reg] <= {cmd_sel, cmd_B, cmd_A};
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg   <= IDLE;
         wr_ptr_reg  <= '0;
         rd_ptr_reg  <= '0;
         count_reg   <= '0;
         settle_reg  <= '0;
         alu_A       <= '0;
         alu_B       <= '0;
         alu_sel     <= '0;
         rsp_valid   <= 1'b0;
         rsp_data    <= '0;
         rsp_flag    <= '0;
         rsp_illegal <= 1'b0;
         err_count   <= '0;
      end else begin
         if (push) begin
            wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
         end
         if (pop) begin
            rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
         end
         case ({push, pop})
            2'b10:   count_reg <= count_reg + (PTR_W + 1)'(1);
            2'b01:   count_reg <= count_reg - (PTR_W + 1)'(1);
            default: count_reg <= count_reg;
         endcase

         if (err_inc && (err_count != '1)) begin
            err_count <= err_count + CNT_W'(1);
         end

         case (state_reg)
            IDLE: begin
               if (pop) begin
                  if (head_legal) begin
                     alu_A      <= head[7:0];
                     alu_B      <= head[15:8];
                     alu_sel    <= head[19:16];
                     settle_reg <= SET_W'(SETTLE_CYC);
                     state_reg  <= SETTLE;
                  end else begin
                     // Illegal opcodes never reach the ALU; answer directly.
                     rsp_data    <= '0;
                     rsp_flag    <= '0;
                     rsp_illegal <= 1'b1;
                     rsp_valid   <= 1'b1;
                     state_reg   <= RESP;
                  end
               end
            end
            SETTLE: begin
               settle_reg <= settle_reg - SET_W'(1);
               if (capture) begin
                  rsp_data    <= alu_out;
                  rsp_flag    <= alu_flag;
                  rsp_illegal <= 1'b0;
                  rsp_valid   <= 1'b1;
                  state_reg   <= RESP;
               end
            end
            RESP: begin
               if (rsp_ready) begin
                  rsp_valid <= 1'b0;
                  state_reg <= IDLE;
               end
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Self-checking bench for alu_op_sequencer: a behavioural ALU closes the loop, and a
// queue-based reference model predicts every response and the error count.
module tb_alu_op_sequencer;

   logic       clk = 1'b0;
   logic       rst;
   logic       cmd_valid;
   logic       cmd_ready;
   logic [7:0] cmd_A;
   logic [7:0] cmd_B;
   logic [3:0] cmd_sel;
   logic [7:0] alu_A;
   logic [7:0] alu_B;
   logic [3:0] alu_sel;
   logic [7:0] alu_out;
   logic [3:0] alu_flag;
   logic       rsp_valid;
   logic       rsp_ready;
   logic [7:0] rsp_data;
   logic [3:0] rsp_flag;
   logic       rsp_illegal;
   logic [7:0] err_count;
   logic       busy;

   int checks = 0;
   int errors = 0;
   int rsp_num = 0;

   typedef struct packed {
      logic [7:0] a;
      logic [7:0] b;
      logic [3:0] sel;
   } cmd_t;

   cmd_t pend_q[$];
   int   exp_err = 0;

   always #5 clk = ~clk;

   alu_op_sequencer #(.FIFO_DEPTH(4), .SETTLE_CYC(1), .CNT_W(8)) dut (
      .clk(clk), .rst(rst),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_A(cmd_A), .cmd_B(cmd_B), .cmd_sel(cmd_sel),
      .alu_A(alu_A), .alu_B(alu_B), .alu_sel(alu_sel),
      .alu_out(alu_out), .alu_flag(alu_flag),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_data(rsp_data), .rsp_flag(rsp_flag), .rsp_illegal(rsp_illegal),
      .err_count(err_count), .busy(busy)
   );

   // Behavioural ALU: returns {flag, out}.
   function automatic logic [11:0] alu_model(input logic [7:0] a, input logic [7:0] b,
                                             input logic [3:0] sel);
      logic [8:0]  wide;
      logic [15:0] prod;
      logic [7:0]  r;
      logic [3:0]  f;
      r = 8'h00;
      f = 4'h0;
      case (sel)
         4'h0: begin wide = {1'b0, a} + {1'b0, b}; r = wide[7:0]; f[1] = wide[8]; end
         4'h1: begin r = a - b; f[3] = (a < b); end
         4'h2: begin prod = 16'(a) * 16'(b); r = prod[7:0]; f[2] = (prod > 16'd255); end
         4'h3: begin if (b == 8'h00) f[3] = 1'b1; else r = a / b; end
         4'h4: begin r = {a[6:0], 1'b0}; f[1] = a[7]; end
         4'h5: r = {1'b0, a[7:1]};
         4'h6: r = {a[6:0], a[7]};
         4'h7: r = {a[0], a[7:1]};
         4'h8: r = a & b;
         4'h9: r = a | b;
         4'hA: r = a ^ b;
         4'hB: r = ~(a | b);
         default: f[3] = 1'b1;
      endcase
      f[0] = (r == 8'h00);
      return {f, r};
   endfunction

   always_comb {alu_flag, alu_out} = alu_model(alu_A, alu_B, alu_sel);

   // Expected response {illegal, flag, data} for a command.
   function automatic logic [12:0] expect_rsp(input cmd_t c);
      if (c.sel > 4'hB) return {1'b1, 12'h000};
      return {1'b0, alu_model(c.a, c.b, c.sel)};
   endfunction

   task automatic do_reset();
      cmd_valid = 1'b0;
      cmd_A     = 8'h00;
      cmd_B     = 8'h00;
      cmd_sel   = 4'h0;
      rsp_ready = 1'b0;
      rst       = 1'b1;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      pend_q.delete();
      exp_err = 0;
   endtask

   // Called at a negedge with inputs already driven: checks state against the model,
   // applies the handshakes of the coming posedge to the model, then advances.
   task automatic step(output bit acc, output bit fire);
      cmd_t        c;
      logic [12:0] e;
      acc  = cmd_valid && cmd_ready;
      fire = rsp_valid && rsp_ready;
      checks++;
      if (busy !== (pend_q.size() != 0)) begin
         errors++;
         $display("FAIL busy: got %b expected %b", busy, pend_q.size() != 0);
      end
      if (rsp_valid) begin
         checks++;
         if (pend_q.size() == 0) begin
            errors++;
            $display("FAIL spurious_rsp: got rsp_valid=1 expected 0 (nothing outstanding)");
         end
      end
      if (fire && pend_q.size() != 0) begin
         c = pend_q.pop_front();
         e = expect_rsp(c);
         if (e[12] || (e[11:9] != 3'b000)) exp_err = (exp_err == 255) ? 255 : exp_err + 1;
         rsp_num++;
         $display("rsp %0d: A=%h B=%h sel=%h -> data=%h flag=%b illegal=%b err=%0d",
                  rsp_num, c.a, c.b, c.sel, rsp_data, rsp_flag, rsp_illegal, err_count);
         checks++;
         if ({rsp_illegal, rsp_flag, rsp_data} !== e) begin
            errors++;
            $display("FAIL rsp_payload: got ill=%b flag=%b data=%h expected ill=%b flag=%b data=%h",
                     rsp_illegal, rsp_flag, rsp_data, e[12], e[11:8], e[7:0]);
         end
         checks++;
         if (err_count !== 8'(exp_err)) begin
            errors++;
            $display("FAIL err_count: got %0d expected %0d", err_count, exp_err);
         end
      end
      if (acc) pend_q.push_back('{a: cmd_A, b: cmd_B, sel: cmd_sel});
      @(negedge clk);
   endtask

   task automatic drain();
      bit acc, fire;
      cmd_valid = 1'b0;
      rsp_ready = 1'b1;
      for (int k = 0; k < 200 && pend_q.size() != 0; k++) step(acc, fire);
      checks++;
      if (pend_q.size() != 0) begin
         errors++;
         $display("FAIL drain: got %0d outstanding expected 0", pend_q.size());
      end
   endtask

   task automatic test_reset();
      do_reset();
      checks++;
      if (cmd_ready !== 1'b1) begin
         errors++;
         $display("FAIL reset_cmd_ready: got %b expected 1", cmd_ready);
      end
      checks++;
      if ({alu_A, alu_B, alu_sel} !== 20'h0) begin
         errors++;
         $display("FAIL reset_alu: got %h %h %h expected 0", alu_A, alu_B, alu_sel);
      end
      checks++;
      if ({rsp_valid, rsp_data, rsp_flag, rsp_illegal, err_count, busy} !== 23'h0) begin
         errors++;
         $display("FAIL reset_rsp: got v=%b d=%h f=%b i=%b e=%0d b=%b expected all 0",
                  rsp_valid, rsp_data, rsp_flag, rsp_illegal, err_count, busy);
      end
   endtask

   task automatic test_add_latency();
      do_reset();
      cmd_valid = 1'b1; cmd_A = 8'h12; cmd_B = 8'h34; cmd_sel = 4'h0;
      @(negedge clk);
      cmd_valid = 1'b0;
      checks++;
      if (rsp_valid !== 1'b0 || busy !== 1'b1) begin
         errors++;
         $display("FAIL add_edge0: got valid=%b busy=%b expected 0 1", rsp_valid, busy);
      end
      @(negedge clk);
      checks++;
      if ({alu_A, alu_B, alu_sel, rsp_valid} !== {8'h12, 8'h34, 4'h0, 1'b0}) begin
         errors++;
         $display("FAIL add_issue: got %h %h %h v=%b expected 12 34 0 v=0",
                  alu_A, alu_B, alu_sel, rsp_valid);
      end
      @(negedge clk);
      checks++;
      if ({rsp_valid, rsp_data, rsp_flag, rsp_illegal, err_count} !== {1'b1, 8'h46, 4'h0, 1'b0, 8'd0}) begin
         errors++;
         $display("FAIL add_capture: got v=%b d=%h f=%b i=%b e=%0d expected v=1 d=46 f=0000 i=0 e=0",
                  rsp_valid, rsp_data, rsp_flag, rsp_illegal, err_count);
      end
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
      checks++;
      if (rsp_valid !== 1'b0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL add_consume: got valid=%b busy=%b expected 0 0", rsp_valid, busy);
      end
   endtask

   task automatic test_underflow_and_illegal();
      do_reset();
      cmd_valid = 1'b1; cmd_A = 8'h05; cmd_B = 8'h09; cmd_sel = 4'h1;
      @(negedge clk);
      cmd_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      checks++;
      if ({rsp_valid, rsp_flag[3], rsp_illegal, rsp_data, err_count} !== {1'b1, 1'b1, 1'b0, 8'hFC, 8'd1}) begin
         errors++;
         $display("FAIL underflow: got v=%b f=%b i=%b d=%h e=%0d expected v=1 f[3]=1 i=0 d=fc e=1",
                  rsp_valid, rsp_flag, rsp_illegal, rsp_data, err_count);
      end
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
      cmd_valid = 1'b1; cmd_A = 8'hFF; cmd_B = 8'hFF; cmd_sel = 4'hE;
      @(negedge clk);
      cmd_valid = 1'b0;
      checks++;
      if (rsp_valid !== 1'b0) begin
         errors++;
         $display("FAIL illegal_early: got valid=%b expected 0", rsp_valid);
      end
      @(negedge clk);
      checks++;
      if ({rsp_valid, rsp_illegal, rsp_data, rsp_flag, err_count} !== {1'b1, 1'b1, 8'h00, 4'h0, 8'd2}) begin
         errors++;
         $display("FAIL illegal_rsp: got v=%b i=%b d=%h f=%b e=%0d expected v=1 i=1 d=00 f=0000 e=2",
                  rsp_valid, rsp_illegal, rsp_data, rsp_flag, err_count);
      end
      checks++;
      if ({alu_A, alu_B, alu_sel} !== {8'h05, 8'h09, 4'h1}) begin
         errors++;
         $display("FAIL illegal_alu_hold: got %h %h %h expected 05 09 1", alu_A, alu_B, alu_sel);
      end
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
   endtask

   task automatic test_backpressure();
      bit acc, fire;
      logic [12:0] e;
      do_reset();
      rsp_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         cmd_valid = 1'b1;
         cmd_A   = 8'($urandom);
         cmd_B   = 8'($urandom);
         cmd_sel = 4'($urandom_range(0, 11));
         checks++;
         if (cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL bp_accept%0d: got cmd_ready=%b expected 1", i, cmd_ready);
         end
         step(acc, fire);
      end
      cmd_A = 8'hAA;
      for (int i = 0; i < 3; i++) begin
         checks++;
         if (cmd_ready !== 1'b0) begin
            errors++;
            $display("FAIL bp_full: got cmd_ready=%b expected 0", cmd_ready);
         end
         step(acc, fire);
      end
      cmd_valid = 1'b0;
      e = expect_rsp(pend_q[0]);
      checks++;
      if ({rsp_valid, rsp_illegal, rsp_flag, rsp_data} !== {1'b1, e}) begin
         errors++;
         $display("FAIL bp_held: got v=%b d=%h expected v=1 d=%h", rsp_valid, rsp_data, e[7:0]);
      end
      drain();
   endtask

   task automatic test_throughput();
      bit acc, fire;
      int last = -1;
      do_reset();
      rsp_ready = 1'b1;
      for (int cyc = 0; cyc < 40; cyc++) begin
         cmd_valid = 1'b1;
         cmd_A   = 8'($urandom);
         cmd_B   = 8'($urandom);
         cmd_sel = 4'($urandom_range(0, 11));
         step(acc, fire);
         if (fire) begin
            if (last >= 0) begin
               checks++;
               if (cyc - last != 3) begin
                  errors++;
                  $display("FAIL throughput: got gap %0d expected 3", cyc - last);
               end
            end
            last = cyc;
         end
      end
      checks++;
      if (last < 0) begin
         errors++;
         $display("FAIL throughput_none: got 0 responses expected some");
      end
      drain();
   endtask

   task automatic test_reset_midop();
      bit acc, fire;
      bit found = 1'b0;
      do_reset();
      rsp_ready = 1'b0;
      for (int i = 1; i <= 5; i++) begin
         cmd_valid = 1'b1;
         cmd_A   = 8'(i);
         cmd_B   = 8'h03;
         cmd_sel = 4'h8;
         step(acc, fire);
      end
      cmd_valid = 1'b0;
      rsp_ready = 1'b1;
      for (int k = 0; k < 10; k++) begin
         if (alu_A === 8'h02) begin
            found = 1'b1;
            break;
         end
         step(acc, fire);
      end
      checks++;
      if (!found || rsp_valid !== 1'b0 || busy !== 1'b1) begin
         errors++;
         $display("FAIL midop_reach: got found=%b valid=%b busy=%b expected 1 0 1", found, rsp_valid, busy);
      end
      #1 rst = 1'b1;
      #1;
      checks++;
      if ({alu_A, alu_B, alu_sel, rsp_valid, rsp_data, rsp_flag, rsp_illegal, err_count, busy, cmd_ready}
          !== 44'h1) begin
         errors++;
         $display("FAIL midop_async: got alu=%h%h%h v=%b d=%h b=%b rdy=%b expected all 0, rdy=1",
                  alu_A, alu_B, alu_sel, rsp_valid, rsp_data, busy, cmd_ready);
      end
      @(negedge clk);
      rst = 1'b0;
      pend_q.delete();
      exp_err = 0;
      for (int k = 0; k < 8; k++) begin
         checks++;
         if (rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL midop_stale: got rsp_valid=%b expected 0", rsp_valid);
         end
         step(acc, fire);
      end
   endtask

   // mode 0: any opcode; mode 1: only error-producing operations.
   task automatic test_random(input int n, input int mode, input int vpct, input int rpct);
      bit acc, fire;
      do_reset();
      for (int cyc = 0; cyc < n; cyc++) begin
         cmd_valid = ($urandom_range(0, 99) < vpct);
         cmd_A = 8'($urandom);
         cmd_B = 8'($urandom);
         if (mode == 0) begin
            cmd_sel = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 7) == 0) cmd_B = 8'h00;
         end else if ($urandom_range(0, 9) < 7) begin
            cmd_sel = 4'($urandom_range(12, 15));
         end else begin
            cmd_sel = 4'h3;
            cmd_B   = 8'h00;
         end
         rsp_ready = ($urandom_range(0, 99) < rpct);
         step(acc, fire);
      end
      drain();
   endtask

   task automatic test_saturation();
      test_random(900, 1, 100, 100);
      checks++;
      if (err_count !== 8'hFF) begin
         errors++;
         $display("FAIL saturation: got %0d expected 255", err_count);
      end
   endtask

   initial begin
      rst = 1'b1;
      cmd_valid = 1'b0; cmd_A = 8'h00; cmd_B = 8'h00; cmd_sel = 4'h0; rsp_ready = 1'b0;
      test_reset();
      test_add_latency();
      test_underflow_and_illegal();
      test_backpressure();
      test_throughput();
      test_reset_midop();
      test_random(600, 0, 60, 60);
      test_saturation();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL timeout: simulation exceeded time limit");
      $fatal(1, "timeout");
   end

endmodule
